// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared mode constants and segment sizing for the add/sub pipeline
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Width of one pipeline segment; guards against a zero stage count so the
  // parameter check in the top can report the problem instead of dividing by zero.
  function automatic int seg_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// rtl/addsub_seg.sv - combinational ripple add/sub slice for one pipeline segment
module addsub_seg
  import addsub_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic           mode,
  output logic [SEG-1:0] s,
  output logic           cout,
  output logic           ovf
);

  logic [SEG-1:0] b_eff;
  logic           c_eff;
  logic           c_raw;

  // Subtract is a + ~b + ~borrow through the same adder; the raw carry is
  // flipped back so cout always reads as carry (ADD) or borrow (SUB).
  always_comb begin
    b_eff        = (mode == MODE_SUB) ? ~b : b;
    c_eff        = (mode == MODE_SUB) ? ~cin : cin;
    {c_raw, s}   = {1'b0, a} + {1'b0, b_eff} + {{SEG{1'b0}}, c_eff};
    cout         = (mode == MODE_SUB) ? ~c_raw : c_raw;
    ovf          = (a[SEG-1] == b_eff[SEG-1]) && (s[SEG-1] != a[SEG-1]);
  end

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - segmented, stallable add/sub pipeline with valid/ready handshake
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("addsub_pipe: WIDTH must be >= 2 and an exact multiple of STAGES >= 1");
  end

  // The whole pipe advances together; it only holds when the output slot is
  // occupied and the consumer refuses it.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG;

    // Operand bits still unresolved when the operation reaches this stage,
    // plus the result bits already resolved below it.
    logic [WIDTH-LO-1:0] src_a;
    logic [WIDTH-LO-1:0] src_b;
    logic                src_vld;
    logic                src_mode;
    logic                src_cin;
    logic [SEG-1:0]      s;
    logic                c;
    logic [LO+SEG-1:0]   res_d;

    if (k == 0) begin : g_src
      assign src_a    = a;
      assign src_b    = b;
      assign src_vld  = in_valid;
      assign src_mode = mode;
      assign src_cin  = cin;
      assign res_d    = s;
    end else begin : g_src
      assign src_a    = g_stage[k-1].g_mid.a_q;
      assign src_b    = g_stage[k-1].g_mid.b_q;
      assign src_vld  = g_stage[k-1].g_mid.vld_q;
      assign src_mode = g_stage[k-1].g_mid.mode_q;
      assign src_cin  = g_stage[k-1].g_mid.c_q;
      assign res_d    = {s, g_stage[k-1].g_mid.res_q};
    end

    if (k < STAGES - 1) begin : g_mid
      logic                    vld_q;
      logic                    mode_q;
      logic                    c_q;
      logic [LO+SEG-1:0]       res_q;
      logic [WIDTH-LO-SEG-1:0] a_q;
      logic [WIDTH-LO-SEG-1:0] b_q;

      // Only the MSB slice can signal a meaningful signed overflow.
      addsub_seg #(.SEG(SEG)) u_seg (
        .a    (src_a[SEG-1:0]),
        .b    (src_b[SEG-1:0]),
        .cin  (src_cin),
        .mode (src_mode),
        .s    (s),
        .cout (c),
        .ovf  ()
      );

      // Intermediate stage: register resolved low bits, chain carry and the skewed upper operands.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
        end else if (adv) begin
          vld_q  <= src_vld;
          mode_q <= src_mode;
          c_q    <= c;
          res_q  <= res_d;
          a_q    <= src_a[WIDTH-LO-1:SEG];
          b_q    <= src_b[WIDTH-LO-1:SEG];
        end
      end
    end else begin : g_last
      logic v;

      addsub_seg #(.SEG(SEG)) u_seg (
        .a    (src_a[SEG-1:0]),
        .b    (src_b[SEG-1:0]),
        .cin  (src_cin),
        .mode (src_mode),
        .s    (s),
        .cout (c),
        .ovf  (v)
      );

      // Final stage doubles as the output holding register.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          result    <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (adv) begin
          out_valid <= src_vld;
          result    <= res_d;
          cout      <= c;
          ovf       <= v;
        end
      end
    end
  end

endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, pipeline depth; SHALL be >= 1; WIDTH % STAGES SHALL be 0; elaboration error otherwise.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operation presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 a  input  WIDTH  minuend / addend A, unsigned or two's complement.
REQ-008 b  input  WIDTH  subtrahend / addend B.
REQ-009 cin  input  1  carry-in (ADD) or borrow-in (SUB).
REQ-010 mode  input  1  0 = ADD, 1 = SUB.
REQ-011 out_valid  output  1  result held.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-014 cout  output  1  ADD: carry-out; SUB: borrow-out.
REQ-015 ovf  output  1  signed two's-complement overflow.

Function
REQ-016 ADD SHALL give {cout,result} = a + b + cin.
REQ-017 SUB SHALL give result = (a - b - cin) mod 2^WIDTH; cout = 1 iff a < b + cin (unsigned).
REQ-018 ovf SHALL be 1 iff the signed result of the selected operation lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-019 Operands SHALL be split into STAGES segments of SEG = WIDTH/STAGES bits; stage k resolves bits [k*SEG +: SEG] using the carry/borrow registered by stage k-1; stage 0 uses cin.
REQ-020 Unresolved upper operand segments and mode SHALL travel with the operation (skewed registers); resolved lower result segments SHALL be carried forward.
REQ-021 Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
REQ-022 Latency: accepted operation SHALL appear with out_valid exactly STAGES cycles after acceptance when no stall occurs.
REQ-023 Throughput: one operation per cycle when out_ready stays 1.
REQ-024 Stall: in_ready = !out_valid || out_ready; when 0, every stage register and valid bit SHALL hold.
REQ-025 Bubbles SHALL propagate (per-stage valid bit); in_ready SHALL NOT depend on in_valid.
REQ-026 result, cout, ovf SHALL be stable while out_valid && !out_ready.
REQ-027 Operations SHALL retire in acceptance order; none dropped or duplicated.
REQ-028 Each operation SHALL use its own mode; mixed ADD/SUB back-to-back SHALL be correct.
REQ-029 STAGES = 1 SHALL degenerate to a single registered full-width add/sub with latency 1.

Reset
REQ-030 While rst_n = 0 at a clock edge: all stage valid bits, out_valid, result, cout, ovf SHALL become 0.
REQ-031 Reset mid-operation SHALL discard all in-flight operations; none emerge afterwards.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-033 Package addsub_pkg SHALL hold mode constants MODE_ADD = 1'b0, MODE_SUB = 1'b1 and the SEG width function.
REQ-034 Sub-module addsub_seg (SEG-bit combinational ripple add/sub slice: a, b, cin, mode -> s, cout, ovf of MSB) SHALL be instantiated once per stage via generate.
REQ-035 Subtraction SHALL be inverted-b plus inverted-borrow through the same slice; no separate subtractor chain.

Verification
REQ-036 WIDTH=32, STAGES=4, out_ready=1: SUB a=0x0000_0000, b=0x0000_0001, cin=0 -> after 4 cycles result=0xFFFF_FFFF, cout=1, ovf=0.
REQ-037 ADD a=0x7FFF_FFFF, b=1, cin=0 -> result=0x8000_0000, cout=0, ovf=1; SUB a=0x8000_0000, b=1 -> result=0x7FFF_FFFF, ovf=1, cout=0.
REQ-038 Back-to-back 8 mixed ops, out_ready=1 -> 8 results on consecutive cycles, order preserved, first at cycle 4.
REQ-039 out_ready=0 for 6 cycles with pipe full -> in_ready=0, result frozen; release -> all 4 held results delivered in order, no loss.
REQ-040 Assert rst_n=0 with 3 ops in flight -> next cycle out_valid=0, flags 0; no stale result after release.
REQ-041 Random 10k ops, WIDTH in {8,16,32}, STAGES in {1,2,4,8 where divisible}, random out_ready -> match reference model a±b±cin.
